// File: rtl/quad_pkg.sv
// Shared phase/direction definitions for the quadrature step decoder slice.
package quad_pkg;

    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } phase_t;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    localparam int unsigned FILTER_CNT_W = 4;

    // Successor of a phase in the forward Gray sequence 00->01->11->10->00.
    function automatic phase_t ph_next_fwd(input phase_t ph);
        phase_t nxt;
        nxt = PH_01;
        case (ph)
            PH_00: nxt = PH_01;
            PH_01: nxt = PH_11;
            PH_11: nxt = PH_10;
            PH_10: nxt = PH_00;
            default: nxt = PH_01;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_chan_filter.sv
// One quadrature channel: 2-flop synchroniser, glitch filter and stability
// detector used for post-reset priming.
module quad_chan_filter
    import quad_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_load,
    output logic o_sync,
    output logic o_filt,
    output logic o_stable
);

    localparam logic [FILTER_CNT_W-1:0] LP_LEN  = FILTER_CNT_W'(FILTER_LEN);
    localparam logic [FILTER_CNT_W-1:0] LP_LAST = FILTER_CNT_W'(FILTER_LEN - 1);

    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_sync_prev;
    logic                    r_filt;
    logic [FILTER_CNT_W-1:0] r_cnt;
    logic [FILTER_CNT_W-1:0] r_stab_cnt;
    logic                    w_same;

    assign w_same   = (r_sync2 == r_sync_prev);
    assign o_sync   = r_sync2;
    assign o_filt   = r_filt;
    // Stable on the FILTER_LEN-th consecutive unchanged sample, and stays so.
    assign o_stable = w_same && (r_stab_cnt >= LP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
            r_filt      <= 1'b0;
            r_cnt       <= '0;
            r_stab_cnt  <= '0;
        end else begin
            r_sync1     <= i_raw;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;

            if (!w_same) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != LP_LEN) begin
                r_stab_cnt <= r_stab_cnt + 1'b1;
            end

            if (i_load) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_LAST) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B to step/direction converter with glitch filtering and
// illegal-transition detection; feeds the up/down counter.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter logic        X4_MODE    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic a_in,
    input  logic b_in,
    input  logic err_clr,
    output logic step,
    output logic up,
    output logic err,
    output logic err_flag
);

    logic       w_sync_a, w_filt_a, w_stable_a;
    logic       w_sync_b, w_filt_b, w_stable_b;
    logic       w_load;
    logic       w_fwd;
    logic       w_err_ev;
    logic [1:0] w_diff;
    phase_t     w_cur;

    logic       r_primed;
    phase_t     r_phase;
    logic       r_step;
    logic       r_up;
    logic       r_err;
    logic       r_err_flag;

    quad_chan_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (a_in),
        .i_load   (w_load),
        .o_sync   (w_sync_a),
        .o_filt   (w_filt_a),
        .o_stable (w_stable_a)
    );

    quad_chan_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (b_in),
        .i_load   (w_load),
        .o_sync   (w_sync_b),
        .o_filt   (w_filt_b),
        .o_stable (w_stable_b)
    );

    assign w_load   = !r_primed && w_stable_a && w_stable_b;
    assign w_cur    = phase_t'({w_filt_a, w_filt_b});
    assign w_diff   = w_cur ^ r_phase;
    assign w_fwd    = (w_cur == ph_next_fwd(r_phase));
    assign w_err_ev = r_primed && (w_diff == 2'b11);

    assign step     = r_step;
    assign up       = r_up;
    assign err      = r_err;
    assign err_flag = r_err_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_primed   <= 1'b0;
            r_phase    <= PH_00;
            r_step     <= 1'b0;
            r_up       <= DIR_FWD;
            r_err      <= 1'b0;
            r_err_flag <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_err  <= 1'b0;
            if (w_load) begin
                // Filters load the same sync values this cycle, so no event follows.
                r_primed <= 1'b1;
                r_phase  <= phase_t'({w_sync_a, w_sync_b});
            end else if (r_primed && (w_diff != 2'b00)) begin
                r_phase <= w_cur;
                if (w_diff == 2'b11) begin
                    r_err <= 1'b1;
                end else begin
                    r_up   <= w_fwd ? DIR_FWD : DIR_REV;
                    r_step <= X4_MODE || (w_cur == PH_00);
                end
            end
            r_err_flag <= w_err_ev || (r_err_flag && !err_clr);
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench: x4 and x1 decoders share randomized A/B stimulus and are
// checked against a cycle-level model of filtered phase events.
module tb_quad_step_decoder;

    localparam int unsigned L = 4;

    typedef struct {
        int unsigned edge_no;
        bit          is_err;
        bit          dir;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_in = 1'b0;
    logic b_in = 1'b0;
    logic err_clr = 1'b0;
    logic step4, up4, err4, flag4;
    logic step1, up1, err1, flag1;

    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_mis = 0;

    ev_t q4[$];
    ev_t q1[$];

    bit          m_a, m_b;
    int unsigned m_cnt_a, m_cnt_b;
    bit [1:0]    m_ph;
    bit [1:0]    seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    quad_step_decoder #(.FILTER_LEN(L), .X4_MODE(1'b1)) u_x4 (
        .clk(clk), .rst(rst_n), .a_in(a_in), .b_in(b_in), .err_clr(err_clr),
        .step(step4), .up(up4), .err(err4), .err_flag(flag4)
    );

    quad_step_decoder #(.FILTER_LEN(L), .X4_MODE(1'b0)) u_x1 (
        .clk(clk), .rst(rst_n), .a_in(a_in), .b_in(b_in), .err_clr(err_clr),
        .step(step1), .up(up1), .err(err1), .err_flag(flag1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pos(input bit [1:0] p);
        for (int k = 0; k < 4; k++) if (seq[k] == p) return k;
        return 0;
    endfunction

    function automatic int unsigned qs(input int i);
        return (i == 0) ? q4.size() : q1.size();
    endfunction

    function automatic ev_t qf(input int i);
        return (i == 0) ? q4[0] : q1[0];
    endfunction

    function automatic void qp(input int i);
        if (i == 0) void'(q4.pop_front());
        else        void'(q1.pop_front());
    endfunction

    task automatic model_reset(input bit [1:0] ab);
        m_a = ab[1]; m_b = ab[0]; m_cnt_a = 0; m_cnt_b = 0; m_ph = ab;
        q4.delete(); q1.delete();
    endtask

    // A channel's filtered value changes after L consecutive differing samples;
    // the resulting output pulse appears 3 edges after that L-th sample.
    task automatic model_cycle(input bit a, input bit b, input int unsigned c);
        bit       ch_a, ch_b;
        bit [1:0] nw;
        ev_t      e;
        ch_a = 0; ch_b = 0;
        if (a != m_a) begin
            m_cnt_a++;
            if (m_cnt_a == L) begin m_a = a; m_cnt_a = 0; ch_a = 1; end
        end else m_cnt_a = 0;
        if (b != m_b) begin
            m_cnt_b++;
            if (m_cnt_b == L) begin m_b = b; m_cnt_b = 0; ch_b = 1; end
        end else m_cnt_b = 0;
        if (ch_a || ch_b) begin
            nw = {m_a, m_b};
            e.edge_no = c + 3;
            if (ch_a && ch_b) begin
                e.is_err = 1; e.dir = 0;
                q4.push_back(e); q1.push_back(e);
            end else begin
                e.is_err = 0;
                e.dir = (pos(nw) == (pos(m_ph) + 1) % 4);
                q4.push_back(e);
                if (nw == 2'b00) q1.push_back(e);
            end
            m_ph = nw;
        end
    endtask

    task automatic apply(input bit [1:0] ab, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk); #1;
            a_in = ab[1]; b_in = ab[0];
            model_cycle(ab[1], ab[0], cyc + 1);
        end
    endtask

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                logic s, e, u;
                ev_t  f;
                s = (i == 0) ? step4 : step1;
                e = (i == 0) ? err4  : err1;
                u = (i == 0) ? up4   : up1;
                while (qs(i) != 0 && qf(i).edge_no < cyc) begin
                    n_vec++; n_mis++;
                    $display("FAIL missed_event dut%0d: no output at edge %0d, required err=%0b", i, qf(i).edge_no, qf(i).is_err);
                    qp(i);
                end
                if (s || e) begin
                    n_vec++;
                    if (s && e) begin
                        n_mis++;
                        $display("FAIL step_err_overlap dut%0d: step and err both 1 at edge %0d", i, cyc);
                    end else if (qs(i) == 0 || qf(i).edge_no != cyc) begin
                        n_mis++;
                        $display("FAIL unexpected_output dut%0d: step=%0b err=%0b at edge %0d, required none", i, s, e, cyc);
                    end else begin
                        f = qf(i);
                        qp(i);
                        if (e != f.is_err || (s && u != f.dir)) begin
                            n_mis++;
                            $display("FAIL event_kind dut%0d: err=%0b up=%0b at edge %0d, required err=%0b up=%0b", i, e, u, cyc, f.is_err, f.dir);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit [1:0]    prev, nxt, g;
        int unsigned r;

        rst_n = 0; a_in = 0; b_in = 0; err_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_x4_step_up_err_flag", {step4, up4, err4, flag4}, 4'b0100);
        chk("reset_x1_step_up_err_flag", {step1, up1, err1, flag1}, 4'b0100);
        model_reset(2'b00);
        rst_n = 1;
        apply(2'b00, 10);

        apply(2'b01, 8); apply(2'b11, 8); apply(2'b10, 8); apply(2'b00, 8);
        chk("fwd_up", up4, 1);
        apply(2'b10, 8); apply(2'b11, 8); apply(2'b01, 8); apply(2'b00, 8);
        chk("rev_up", up4, 0);

        apply(2'b10, L - 1); apply(2'b00, 10);

        apply(2'b11, 8);
        chk("err_flag_set", flag4, 1);
        chk("up_held_on_err", up4, 0);
        apply(2'b00, 7);
        err_clr = 1;
        apply(2'b00, 1);
        chk("err_flag_set_wins", flag4, 1);
        chk("err_flag_set_wins_x1", flag1, 1);
        apply(2'b00, 1);
        chk("err_flag_cleared", flag4, 0);
        err_clr = 0;
        apply(2'b00, 4);

        apply(2'b10, 8); apply(2'b11, 8); apply(2'b00, 8); apply(2'b11, 8);
        chk("pre_reset_up_x4", up4, 0);
        chk("pre_reset_up_x1", up1, 0);
        chk("pre_reset_flag", flag4, 1);

        @(posedge clk); #2;
        rst_n = 0;
        model_reset(2'b11);
        #1;
        chk("async_reset_x4", {step4, up4, err4, flag4}, 4'b0100);
        chk("async_reset_x1", {step1, up1, err1, flag1}, 4'b0100);
        @(posedge clk); #1;
        rst_n = 1;
        apply(2'b11, 20);
        apply(2'b10, 8);
        chk("post_reset_up", up4, 1);

        prev = 2'b10;
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                nxt = prev ^ 2'b11;
            end else if (r <= 2) begin
                g = prev ^ ((r == 1) ? 2'b10 : 2'b01);
                apply(g, $urandom_range(1, L - 1));
                nxt = prev;
            end else begin
                nxt = ($urandom_range(0, 1) == 1) ? seq[(pos(prev) + 1) % 4] : seq[(pos(prev) + 3) % 4];
            end
            apply(nxt, $urandom_range(1, 12));
            prev = nxt;
        end
        apply(prev, 20);
        chk("x4_queue_drained", q4.size(), 0);
        chk("x1_queue_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
